reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Receiving end of the issuer->RS interface: buffers issued ALU/branch ops
//  (operands or ROB-tag deps), wakes them from CDB broadcasts, and dispatches
//  one ready op per cycle to the ALU. Sits between instruction issue and ALU;
//  asserts rs_full so instruction fetch stalls before the station overflows.
// PARAMETERS
//  RS_SIZE   16  entries; power of two, >=4
//  ROB_W     6   ROB index width (matches issuer rob_index/dep width)
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, synchronous, active-high
//  rdy            in   1      global enable; low = hold all state and outputs
//  flush          in   1      mispredict flush from CDB
//  rs_valid       in   1      issue strobe from issuer
//  rs_opcode      in   6      decoded opcode
//  rs_val1/val2   in   32     operand values (valid when !has_dep)
//  rs_dep1/dep2   in   ROB_W  producer ROB tag
//  rs_has_dep1/2  in   1      operand pending
//  rs_rob_index   in   ROB_W  destination ROB entry
//  rs_imm, rs_pc  in   32     immediate, instruction PC
//  rs_full        out  1      to IF: stop fetching
//  cdb_alu_valid  in   1      ALU result broadcast
//  cdb_alu_index  in   ROB_W  / cdb_alu_value in 32
//  cdb_lsb_valid  in   1      load result broadcast
//  cdb_lsb_index  in   ROB_W  / cdb_lsb_value in 32
//  alu_valid      out  1      dispatch strobe, one cycle per op
//  alu_opcode     out  6      / alu_val1, alu_val2, alu_imm, alu_pc out 32
//  alu_rob_index  out  ROB_W
// BEHAVIOUR
//  Reset/flush (rdy high): all busy bits 0, count 0, alu_valid 0, all alu_*
//   data 0 on reset (held on flush); issue and CDB in that cycle ignored.
//  rdy low: no allocate, wakeup or dispatch; every register holds.
//  Per entry: busy, opcode, val1/2, dep1/2, has_dep1/2, rob_index, imm, pc.
//  Allocate: rs_valid -> lowest-index entry with busy=0 at cycle start.
//   Slot freed by dispatch in the same cycle is NOT reused until next cycle.
//   Incoming operand with has_dep and dep==matching valid CDB index this
//   cycle is captured as value (has_dep=0) on allocation (bypass).
//   rs_valid with no free slot: op dropped, count unchanged (protocol error).
//  Wakeup: every busy entry with has_depN && depN==cdb_*_index && cdb_*_valid
//   -> valN<=value, has_depN<=0. ALU port checked first; both ports may hit
//   different operands in one cycle; dep tag cleared to 0 on capture.
//  Ready = busy && !has_dep1 && !has_dep2, evaluated on registered state;
//   an entry woken this cycle is eligible next cycle (1-cycle wake latency).
//  Dispatch: lowest-index ready entry -> alu_* registered, alu_valid=1 next
//   edge; entry busy<=0. No ready entry -> alu_valid<=0. Issue->dispatch
//   minimum latency 2 cycles (allocate, then select).
//  count (clog2(RS_SIZE)+1 bits): +1 alloc, -1 dispatch, net 0 on both.
//  rs_full = (count >= RS_SIZE-2), combinational; 2-slot margin covers the
//   op already registered in issuer plus the one in decode.
//  No ordering guarantee between entries; ROB enforces program order.
// TESTING
//  1. Issue ADDI val1=5,imm=3,no deps -> alu_valid 2 cycles later, val1=5,
//     imm=3, rob_index echoed; count back to 0.
//  2. Issue ADD has_dep1 tag 7; cdb_alu 7=0x10 two cycles later -> dispatch
//     the cycle after wakeup with val1=0x10; no earlier alu_valid.
//  3. Issue with dep tag 9 in same cycle as cdb_lsb 9=0xAB -> bypass,
//     dispatches 2 cycles after issue with val=0xAB.
//  4. Fill 14 independent-blocked entries -> rs_full high at count 14;
//     wake all at once -> 14 dispatches on consecutive cycles, index order.
//  5. flush with 5 busy entries + concurrent rs_valid -> next cycle count 0,
//     alu_valid 0, rs_full 0; later CDB hits cause no dispatch.
//  6. rdy low 3 cycles mid-stream with CDB hit -> outputs frozen, hit lost;
//     resume matches reference model.

Source files
------------

// File: rtl/reservation_station.sv
// Reservation station: buffers issued ALU/branch ops, wakes operands from the two
// CDB ports and dispatches the lowest-index ready op to the ALU each cycle.
module reservation_station #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned ROB_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             rs_valid,
    input  logic [5:0]       rs_opcode,
    input  logic [31:0]      rs_val1,
    input  logic [31:0]      rs_val2,
    input  logic [ROB_W-1:0] rs_dep1,
    input  logic [ROB_W-1:0] rs_dep2,
    input  logic             rs_has_dep1,
    input  logic             rs_has_dep2,
    input  logic [ROB_W-1:0] rs_rob_index,
    input  logic [31:0]      rs_imm,
    input  logic [31:0]      rs_pc,
    output logic             rs_full,
    input  logic             cdb_alu_valid,
    input  logic [ROB_W-1:0] cdb_alu_index,
    input  logic [31:0]      cdb_alu_value,
    input  logic             cdb_lsb_valid,
    input  logic [ROB_W-1:0] cdb_lsb_index,
    input  logic [31:0]      cdb_lsb_value,
    output logic             alu_valid,
    output logic [5:0]       alu_opcode,
    output logic [31:0]      alu_val1,
    output logic [31:0]      alu_val2,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [ROB_W-1:0] alu_rob_index
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef struct packed {
        logic             busy;
        logic [5:0]       opcode;
        logic [31:0]      val1;
        logic [31:0]      val2;
        logic [ROB_W-1:0] dep1;
        logic [ROB_W-1:0] dep2;
        logic             has_dep1;
        logic             has_dep2;
        logic [ROB_W-1:0] rob;
        logic [31:0]      imm;
        logic [31:0]      pc;
    } entry_t;

    entry_t           ent_q [RS_SIZE];
    entry_t           ent_d [RS_SIZE];
    entry_t           new_ent;
    logic [CNT_W-1:0] count_q, count_d;

    logic             alu_valid_q, alu_valid_d;
    logic [5:0]       alu_opcode_q, alu_opcode_d;
    logic [31:0]      alu_val1_q, alu_val1_d;
    logic [31:0]      alu_val2_q, alu_val2_d;
    logic [31:0]      alu_imm_q, alu_imm_d;
    logic [31:0]      alu_pc_q, alu_pc_d;
    logic [ROB_W-1:0] alu_rob_q, alu_rob_d;

    logic             free_found, ready_found, do_alloc;
    logic [IDX_W-1:0] free_idx, ready_idx;

    // Priority pick on registered state: lowest free slot, lowest ready entry.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_q[i].busy && !ent_q[i].has_dep1 && !ent_q[i].has_dep2) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end
    end

    // Incoming op, with same-cycle CDB bypass on its operands.
    always_comb begin
        new_ent          = '0;
        new_ent.busy     = 1'b1;
        new_ent.opcode   = rs_opcode;
        new_ent.val1     = rs_val1;
        new_ent.val2     = rs_val2;
        new_ent.rob      = rs_rob_index;
        new_ent.imm      = rs_imm;
        new_ent.pc       = rs_pc;
        new_ent.has_dep1 = rs_has_dep1;
        new_ent.has_dep2 = rs_has_dep2;
        new_ent.dep1     = rs_has_dep1 ? rs_dep1 : '0;
        new_ent.dep2     = rs_has_dep2 ? rs_dep2 : '0;
        if (rs_has_dep1 && cdb_alu_valid && rs_dep1 == cdb_alu_index) begin
            new_ent.val1 = cdb_alu_value; new_ent.has_dep1 = 1'b0; new_ent.dep1 = '0;
        end else if (rs_has_dep1 && cdb_lsb_valid && rs_dep1 == cdb_lsb_index) begin
            new_ent.val1 = cdb_lsb_value; new_ent.has_dep1 = 1'b0; new_ent.dep1 = '0;
        end
        if (rs_has_dep2 && cdb_alu_valid && rs_dep2 == cdb_alu_index) begin
            new_ent.val2 = cdb_alu_value; new_ent.has_dep2 = 1'b0; new_ent.dep2 = '0;
        end else if (rs_has_dep2 && cdb_lsb_valid && rs_dep2 == cdb_lsb_index) begin
            new_ent.val2 = cdb_lsb_value; new_ent.has_dep2 = 1'b0; new_ent.dep2 = '0;
        end
    end

    assign do_alloc = rs_valid && free_found;

    // Next state: wakeup, then dispatch, then allocate; flush overrides.
    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                if (ent_q[i].has_dep1 && cdb_alu_valid && ent_q[i].dep1 == cdb_alu_index) begin
                    ent_d[i].val1 = cdb_alu_value; ent_d[i].has_dep1 = 1'b0; ent_d[i].dep1 = '0;
                end else if (ent_q[i].has_dep1 && cdb_lsb_valid && ent_q[i].dep1 == cdb_lsb_index) begin
                    ent_d[i].val1 = cdb_lsb_value; ent_d[i].has_dep1 = 1'b0; ent_d[i].dep1 = '0;
                end
                if (ent_q[i].has_dep2 && cdb_alu_valid && ent_q[i].dep2 == cdb_alu_index) begin
                    ent_d[i].val2 = cdb_alu_value; ent_d[i].has_dep2 = 1'b0; ent_d[i].dep2 = '0;
                end else if (ent_q[i].has_dep2 && cdb_lsb_valid && ent_q[i].dep2 == cdb_lsb_index) begin
                    ent_d[i].val2 = cdb_lsb_value; ent_d[i].has_dep2 = 1'b0; ent_d[i].dep2 = '0;
                end
            end
        end

        alu_valid_d  = ready_found;
        alu_opcode_d = alu_opcode_q;
        alu_val1_d   = alu_val1_q;
        alu_val2_d   = alu_val2_q;
        alu_imm_d    = alu_imm_q;
        alu_pc_d     = alu_pc_q;
        alu_rob_d    = alu_rob_q;
        if (ready_found) begin
            ent_d[ready_idx].busy = 1'b0;
            alu_opcode_d = ent_q[ready_idx].opcode;
            alu_val1_d   = ent_q[ready_idx].val1;
            alu_val2_d   = ent_q[ready_idx].val2;
            alu_imm_d    = ent_q[ready_idx].imm;
            alu_pc_d     = ent_q[ready_idx].pc;
            alu_rob_d    = ent_q[ready_idx].rob;
        end

        // free_idx was idle at cycle start, so it never collides with the dispatched slot
        if (do_alloc) begin
            ent_d[free_idx] = new_ent;
        end

        count_d = count_q + CNT_W'(do_alloc) - CNT_W'(ready_found);

        if (flush) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent_d[i].busy = 1'b0;
            end
            count_d     = '0;
            alu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent_q[i] <= '0;
            end
            count_q      <= '0;
            alu_valid_q  <= 1'b0;
            alu_opcode_q <= '0;
            alu_val1_q   <= '0;
            alu_val2_q   <= '0;
            alu_imm_q    <= '0;
            alu_pc_q     <= '0;
            alu_rob_q    <= '0;
        end else if (rdy) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q      <= count_d;
            alu_valid_q  <= alu_valid_d;
            alu_opcode_q <= alu_opcode_d;
            alu_val1_q   <= alu_val1_d;
            alu_val2_q   <= alu_val2_d;
            alu_imm_q    <= alu_imm_d;
            alu_pc_q     <= alu_pc_d;
            alu_rob_q    <= alu_rob_d;
        end
    end

    // Two-slot margin absorbs the ops already in flight in decode and issue.
    assign rs_full       = (count_q >= CNT_W'(RS_SIZE - 2));
    assign alu_valid     = alu_valid_q;
    assign alu_opcode    = alu_opcode_q;
    assign alu_val1      = alu_val1_q;
    assign alu_val2      = alu_val2_q;
    assign alu_imm       = alu_imm_q;
    assign alu_pc        = alu_pc_q;
    assign alu_rob_index = alu_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station: issue, wakeup, bypass, full, flush, rdy stall.
module tb_reservation_station;

    localparam int unsigned ROB_W = 6;

    logic             clk = 1'b0;
    logic             rst, rdy, flush, rs_valid;
    logic [5:0]       rs_opcode;
    logic [31:0]      rs_val1, rs_val2, rs_imm, rs_pc;
    logic [ROB_W-1:0] rs_dep1, rs_dep2, rs_rob_index;
    logic             rs_has_dep1, rs_has_dep2, rs_full;
    logic             cdb_alu_valid, cdb_lsb_valid;
    logic [ROB_W-1:0] cdb_alu_index, cdb_lsb_index;
    logic [31:0]      cdb_alu_value, cdb_lsb_value;
    logic             alu_valid;
    logic [5:0]       alu_opcode;
    logic [31:0]      alu_val1, alu_val2, alu_imm, alu_pc;
    logic [ROB_W-1:0] alu_rob_index;

    int errors = 0;
    int checks = 0;

    reservation_station #(.RS_SIZE(16), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .rs_valid(rs_valid), .rs_opcode(rs_opcode),
        .rs_val1(rs_val1), .rs_val2(rs_val2),
        .rs_dep1(rs_dep1), .rs_dep2(rs_dep2),
        .rs_has_dep1(rs_has_dep1), .rs_has_dep2(rs_has_dep2),
        .rs_rob_index(rs_rob_index), .rs_imm(rs_imm), .rs_pc(rs_pc),
        .rs_full(rs_full),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_index(cdb_alu_index), .cdb_alu_value(cdb_alu_value),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_index(cdb_lsb_index), .cdb_lsb_value(cdb_lsb_value),
        .alu_valid(alu_valid), .alu_opcode(alu_opcode),
        .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_index(alu_rob_index)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; rs_valid = 0; rs_opcode = 0; rs_val1 = 0; rs_val2 = 0;
        rs_dep1 = 0; rs_dep2 = 0; rs_has_dep1 = 0; rs_has_dep2 = 0;
        rs_rob_index = 0; rs_imm = 0; rs_pc = 0;
        cdb_alu_valid = 0; cdb_alu_index = 0; cdb_alu_value = 0;
        cdb_lsb_valid = 0; cdb_lsb_index = 0; cdb_lsb_value = 0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic hd1, input logic [ROB_W-1:0] d1,
                         input logic hd2, input logic [ROB_W-1:0] d2,
                         input logic [ROB_W-1:0] rob, input logic [31:0] imm, input logic [31:0] pc);
        rs_valid = 1; rs_opcode = op; rs_val1 = v1; rs_val2 = v2;
        rs_has_dep1 = hd1; rs_dep1 = d1; rs_has_dep2 = hd2; rs_dep2 = d2;
        rs_rob_index = rob; rs_imm = imm; rs_pc = pc;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; rdy = 1;
        step(); step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid got=%b want=0", alu_valid); end
        checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL reset_rs_full got=%b want=0", rs_full); end
        checks++; if (alu_val1 !== 32'h0 || alu_rob_index !== 6'd0 || alu_pc !== 32'h0)
            begin errors++; $display("FAIL reset_alu_data got val1=%h rob=%0d pc=%h want 0", alu_val1, alu_rob_index, alu_pc); end
        rst = 0;
    endtask

    task automatic test_basic_dispatch();
        issue(6'h13, 32'd5, 32'd0, 0, 0, 0, 0, 6'd3, 32'd3, 32'h100);
        step(); clear_inputs();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL basic_early got=%b want=0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b want=1", alu_valid); end
        checks++; if (alu_val1 !== 32'd5 || alu_imm !== 32'd3 || alu_rob_index !== 6'd3 || alu_opcode !== 6'h13 || alu_pc !== 32'h100)
            begin errors++; $display("FAIL basic_data got val1=%0d imm=%0d rob=%0d op=%h pc=%h want 5 3 3 13 100",
                                     alu_val1, alu_imm, alu_rob_index, alu_opcode, alu_pc); end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got=%b want=0", alu_valid); end
    endtask

    task automatic test_wakeup();
        issue(6'h01, 32'd0, 32'd2, 1, 6'd7, 0, 0, 6'd4, 32'd0, 32'h200);
        step(); clear_inputs();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL wake_c1 got=%b want=0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL wake_c2 got=%b want=0", alu_valid); end
        cdb_alu_valid = 1; cdb_alu_index = 6'd7; cdb_alu_value = 32'h10;
        step(); clear_inputs();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL wake_latency got=%b want=0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b1 || alu_val1 !== 32'h10 || alu_val2 !== 32'd2 || alu_rob_index !== 6'd4)
            begin errors++; $display("FAIL wake_dispatch got v=%b val1=%h val2=%h rob=%0d want 1 10 2 4",
                                     alu_valid, alu_val1, alu_val2, alu_rob_index); end
        step();
    endtask

    task automatic test_bypass();
        issue(6'h02, 32'd0, 32'd5, 1, 6'd9, 0, 0, 6'd5, 32'd0, 32'h300);
        cdb_lsb_valid = 1; cdb_lsb_index = 6'd9; cdb_lsb_value = 32'hAB;
        step(); clear_inputs();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL bypass_early got=%b want=0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b1 || alu_val1 !== 32'hAB || alu_rob_index !== 6'd5)
            begin errors++; $display("FAIL bypass_dispatch got v=%b val1=%h rob=%0d want 1 ab 5", alu_valid, alu_val1, alu_rob_index); end
        step();
    endtask

    task automatic test_dual_cdb();
        issue(6'h03, 32'd0, 32'd0, 1, 6'd5, 1, 6'd6, 6'd6, 32'd0, 32'h400);
        step(); clear_inputs();
        cdb_alu_valid = 1; cdb_alu_index = 6'd5; cdb_alu_value = 32'hA;
        cdb_lsb_valid = 1; cdb_lsb_index = 6'd6; cdb_lsb_value = 32'hB;
        step(); clear_inputs();
        step();
        checks++; if (alu_valid !== 1'b1 || alu_val1 !== 32'hA || alu_val2 !== 32'hB)
            begin errors++; $display("FAIL dual_cdb got v=%b val1=%h val2=%h want 1 a b", alu_valid, alu_val1, alu_val2); end
        step();
    endtask

    task automatic test_full_and_drain();
        for (int i = 0; i < 14; i++) begin
            issue(6'h04, 32'd0, 32'(i), 1, 6'd20, 0, 0, 6'(i), 32'd0, 32'h500);
            step();
            checks++; if (rs_full !== ((i + 1) >= 14) || alu_valid !== 1'b0)
                begin errors++; $display("FAIL fill_%0d got full=%b v=%b want full=%b v=0", i, rs_full, alu_valid, (i + 1) >= 14); end
        end
        clear_inputs();
        cdb_alu_valid = 1; cdb_alu_index = 6'd20; cdb_alu_value = 32'h55;
        step(); clear_inputs();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL drain_latency got=%b want=0", alu_valid); end
        for (int i = 0; i < 14; i++) begin
            step();
            checks++; if (alu_valid !== 1'b1 || alu_rob_index !== 6'(i) || alu_val1 !== 32'h55 || alu_val2 !== 32'(i) || rs_full !== 1'b0)
                begin errors++; $display("FAIL drain_%0d got v=%b rob=%0d val1=%h val2=%0d full=%b want 1 %0d 55 %0d 0",
                                         i, alu_valid, alu_rob_index, alu_val1, alu_val2, rs_full, i, i); end
        end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL drain_end got=%b want=0", alu_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            issue(6'h05, 32'd0, 32'd0, 1, 6'd30, 0, 0, 6'(20 + i), 32'd0, 32'h600);
            step();
        end
        issue(6'h06, 32'd1, 32'd1, 0, 0, 0, 0, 6'd40, 32'd0, 32'h700);
        flush = 1;
        step(); clear_inputs();
        checks++; if (alu_valid !== 1'b0 || rs_full !== 1'b0 || alu_rob_index !== 6'd13)
            begin errors++; $display("FAIL flush_state got v=%b full=%b rob=%0d want 0 0 13", alu_valid, rs_full, alu_rob_index); end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_ignored got=%b want=0", alu_valid); end
        cdb_alu_valid = 1; cdb_alu_index = 6'd30; cdb_alu_value = 32'h99;
        step(); clear_inputs();
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_no_wake got=%b want=0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_no_wake2 got=%b want=0", alu_valid); end
    endtask

    task automatic test_rdy_stall();
        issue(6'h07, 32'h11, 32'd0, 0, 0, 0, 0, 6'd1, 32'd0, 32'h800);
        step();
        issue(6'h08, 32'd0, 32'd0, 1, 6'd12, 0, 0, 6'd2, 32'd0, 32'h804);
        step(); clear_inputs();
        checks++; if (alu_valid !== 1'b1 || alu_rob_index !== 6'd1 || alu_val1 !== 32'h11)
            begin errors++; $display("FAIL rdy_pre got v=%b rob=%0d val1=%h want 1 1 11", alu_valid, alu_rob_index, alu_val1); end
        rdy = 0;
        cdb_alu_valid = 1; cdb_alu_index = 6'd12; cdb_alu_value = 32'h77;
        issue(6'h09, 32'd3, 32'd3, 0, 0, 0, 0, 6'd3, 32'd0, 32'h808);
        for (int i = 0; i < 3; i++) begin
            step();
            cdb_alu_valid = 0;
            checks++; if (alu_valid !== 1'b1 || alu_rob_index !== 6'd1)
                begin errors++; $display("FAIL rdy_frozen_%0d got v=%b rob=%0d want 1 1", i, alu_valid, alu_rob_index); end
        end
        rdy = 1; clear_inputs();
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL rdy_hit_lost got=%b want=0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL rdy_no_alloc got=%b want=0", alu_valid); end
        cdb_alu_valid = 1; cdb_alu_index = 6'd12; cdb_alu_value = 32'h99;
        step(); clear_inputs();
        step();
        checks++; if (alu_valid !== 1'b1 || alu_rob_index !== 6'd2 || alu_val1 !== 32'h99)
            begin errors++; $display("FAIL rdy_resume got v=%b rob=%0d val1=%h want 1 2 99", alu_valid, alu_rob_index, alu_val1); end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL rdy_end got=%b want=0", alu_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_dispatch();
        test_wakeup();
        test_bypass();
        test_dual_cdb();
        test_full_and_drain();
        test_flush();
        test_rdy_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
